regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the octal D-register bank (74377-style, active-low enable, capture on rising clock) between several write requesters.
- Selects one requester per cycle using round-robin priority, with optional locked bursts.
- Drives the shared 8-bit D bus and one active-low enable per register.
- Sits between the CPU execution sources (ALU result, load data, immediate) and the register bank. The bank clock is the same `clk`.

Parameters:
- NREQ, 3, number of write requesters.
- NREG, 4, number of octal registers in the bank.
- W, 8, data width.
- SELW, 2, register index width (clog2 of NREG).
- MAX_BURST, 4, maximum consecutive grants to one locked owner.

Ports:
- clk  in  1  system clock; also clocks the register bank.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request (level).
- req_lock  in  NREQ  per-requester burst-lock request; only meaningful together with req.
- req_sel  in  NREQ*SELW  destination register index per requester (packed, requester 0 in LSBs).
- req_data  in  NREQ*W  write data per requester (packed).
- ack  out  NREQ  one-hot grant pulse; high during the cycle its write is presented to the bank.
- wr_en_n  out  NREG  active-low per-register enable to the bank.
- wr_data  out  W  shared D bus to the bank.
- busy  out  1  high while state is LOCK.
- err  out  1  sticky flag: a granted write targeted req_sel >= NREG.

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - wr_en_n all 1, wr_data 0, ack 0, busy 0, err 0.
  - Round-robin pointer rr = 0, state IDLE, burst count 0.
  - Assertion mid-write forces wr_en_n high immediately, so no capture occurs at the next edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Write timing:
  - Edge k samples the request and registers ack, wr_data and wr_en_n.
  - Edge k+1 captures the data into the bank.
  - Request-to-register latency is therefore 2 edges.
- Cycle with no grant: wr_en_n all 1 and ack 0. wr_data holds its last value, so the bank holds.
- Eligibility: req[i]=1, and ack[i]=0 unless i is the LOCK owner. A requester holding req continuously without lock is therefore granted at most every other cycle. This prevents a double write before the requester can react to ack.
- Round-robin (IDLE):
  - Winner is the first eligible index scanning rr, rr+1, … mod NREQ.
  - On a grant, rr <= winner+1 mod NREQ. On no grant, rr is unchanged.
- Grant actions:
  - ack <= onehot(winner).
  - wr_data <= req_data[winner].
  - wr_en_n <= ~onehot(req_sel[winner]).
  - If req_sel[winner] >= NREG: wr_en_n all 1, ack still pulses, err <= 1.
- FSM states are IDLE and LOCK.
  - IDLE -> LOCK: the winner has req_lock=1. owner <= winner, burst count <= 1, busy <= 1.
  - In LOCK, each edge:
    - If req[owner] & req_lock[owner] and count < MAX_BURST: grant the owner again (ack is high every cycle), count+1, rr unchanged.
    - Otherwise: return to IDLE and perform normal round-robin in that same edge, with the owner excluded. No idle bubble is inserted.
  - LOCK owner changing req_sel mid-burst is legal; each beat uses the current req_sel.
- Simultaneous requests to the same register from different requesters are serialised by arbitration, so there is never more than one wr_en_n low.
- req_lock without req is ignored.
- err clears only on reset.

Decomposition:
- Package regfile_arb_pkg holds:
  - state encoding (ST_IDLE, ST_LOCK);
  - default widths;
  - a function onehot(idx).
- Sub-module rr_pick is the natural split: combinational round-robin picker with inputs eligible[NREQ] and rr, outputs winner index and valid. The top level holds the FSM, counters and output registers.

Test Plan:
- Reset: drive rst_n=0 mid-grant -> wr_en_n=4'b1111 and ack=0 immediately; after release, idle with no req keeps wr_en_n=1111.
- Single write: req[1]=1, req_sel[1]=2, data 0xA5 at edge 0 -> after edge 0, ack=3'b010, wr_en_n=4'b1011, wr_data=0xA5; reg2 reads 0xA5 after edge 1; ack low after edge 1 with req dropped.
- Round-robin: req=3'b111 held, no lock, rr=0 -> grant order 0,1,2,0…; no requester acked on consecutive edges; each write lands in its own req_sel register.
- Lock burst: req[2]+req_lock[2] held, req[0] also high -> ack[2] for exactly 4 consecutive cycles (MAX_BURST), busy=1, then ack[0] on the very next cycle with busy=0.
- Early lock release: owner drops req_lock after 2 beats -> the third edge grants another requester; count resets for the next lock.
- Invalid index: with NREG=3 and SELW=2, req_sel=3 -> ack pulses, wr_en_n all 1, no register changes, err=1 and stays 1 until rst_n.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: default sizes,
// FSM state encoding and the one-hot decode helper.
package regfile_arb_pkg;

    localparam int NREQ_D      = 3;
    localparam int NREG_D      = 4;
    localparam int W_D         = 8;
    localparam int SELW_D      = 2;
    localparam int MAX_BURST_D = 4;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bundle between the write sources and the arbiter, plus the
// register-bank side (D bus, active-low enables) and status flags.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int NREG = NREG_D,
    parameter int W    = W_D,
    parameter int SELW = SELW_D
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ*W-1:0]    req_data;
    logic [NREQ-1:0]      ack;
    logic [NREG-1:0]      wr_en_n;
    logic [W-1:0]         wr_data;
    logic                 busy;
    logic                 err;

    modport master (
        output req, req_lock, req_sel, req_data,
        input  ack, wr_en_n, wr_data, busy, err
    );

    modport slave (
        input  req, req_lock, req_sel, req_data,
        output ack, wr_en_n, wr_data, busy, err
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDXW-1:0] rr,
    output logic [IDXW-1:0] winner,
    output logic            valid
);

    // Scan from the farthest offset back toward rr so the nearest eligible index wins
    always_comb begin
        winner = {IDXW{1'b0}};
        valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            valid  = valid | eligible[(int'(rr) + k) % NREQ];
            winner = eligible[(int'(rr) + k) % NREQ] ? IDXW'((int'(rr) + k) % NREQ) : winner;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter for a 74377-style octal register bank, with
// bounded locked bursts. Every output is registered.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_D,
    parameter int NREG      = NREG_D,
    parameter int W         = W_D,
    parameter int SELW      = SELW_D,
    parameter int MAX_BURST = MAX_BURST_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    state_t            state_r, state_nxt_s;
    logic [IDXW-1:0]   owner_r, owner_nxt_s, rr_r, rr_nxt_s, pick_s, gidx_s;
    logic [CNTW-1:0]   cnt_r, cnt_nxt_s;
    logic [NREQ-1:0]   eligible_s, ack_r, ack_nxt_s;
    logic [NREG-1:0]   wr_en_n_r, wr_en_n_nxt_s;
    logic [W-1:0]      wr_data_r, wr_data_nxt_s, gdata_s;
    logic [SELW-1:0]   gsel_s;
    logic              pick_valid_s, lock_cont_s, grant_s, sel_ok_s;
    logic              busy_r, err_r, err_nxt_s;

    // A requester acked last cycle sits out one cycle unless it owns the lock
    always_comb begin
        eligible_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            eligible_s[i] = bus.req[i] & ~ack_r[i]
                          & ~((state_r == ST_LOCK) & (owner_r == IDXW'(i)));
        end
    end

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .eligible (eligible_s),
        .rr       (rr_r),
        .winner   (pick_s),
        .valid    (pick_valid_s)
    );

    // Choose between continuing the locked burst and a fresh round-robin grant
    always_comb begin
        lock_cont_s = (state_r == ST_LOCK) && bus.req[owner_r] && bus.req_lock[owner_r]
                      && (cnt_r < CNTW'(MAX_BURST));
        grant_s     = lock_cont_s | pick_valid_s;
        gidx_s      = lock_cont_s ? owner_r : pick_s;
        gsel_s      = bus.req_sel[gidx_s*SELW +: SELW];
        gdata_s     = bus.req_data[gidx_s*W +: W];
        sel_ok_s    = (32'(gsel_s) < 32'(NREG));
    end

    // FSM, burst counter and round-robin pointer next state
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        cnt_nxt_s   = cnt_r;
        rr_nxt_s    = rr_r;
        if (lock_cont_s) begin
            cnt_nxt_s = cnt_r + CNTW'(1);
        end else if (pick_valid_s) begin
            rr_nxt_s = (pick_s == IDXW'(NREQ - 1)) ? {IDXW{1'b0}} : pick_s + IDXW'(1);
            if (bus.req_lock[pick_s]) begin
                state_nxt_s = ST_LOCK;
                owner_nxt_s = pick_s;
                cnt_nxt_s   = CNTW'(1);
            end else begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNTW{1'b0}};
            end
        end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNTW{1'b0}};
        end
    end

    // Output next values; an out-of-range index still acks but enables nothing
    always_comb begin
        ack_nxt_s     = grant_s ? NREQ'(onehot(32'(gidx_s))) : {NREQ{1'b0}};
        wr_data_nxt_s = grant_s ? gdata_s : wr_data_r;
        wr_en_n_nxt_s = (grant_s && sel_ok_s) ? ~NREG'(onehot(32'(gsel_s))) : {NREG{1'b1}};
        err_nxt_s     = err_r | (grant_s & ~sel_ok_s);
    end

    // State and output registers; reset drops every enable immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            owner_r   <= {IDXW{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
            rr_r      <= {IDXW{1'b0}};
            ack_r     <= {NREQ{1'b0}};
            wr_en_n_r <= {NREG{1'b1}};
            wr_data_r <= {W{1'b0}};
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rr_r      <= rr_nxt_s;
            ack_r     <= ack_nxt_s;
            wr_en_n_r <= wr_en_n_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            busy_r    <= (state_nxt_s == ST_LOCK);
            err_r     <= err_nxt_s;
        end
    end

    assign bus.ack     = ack_r;
    assign bus.wr_en_n = wr_en_n_r;
    assign bus.wr_data = wr_data_r;
    assign bus.busy    = busy_r;
    assign bus.err     = err_r;

endmodule
